frog_rider_ctrl: RTL and testbench
==================================

FROG_RIDER_CTRL -- requirements
Module: frog_rider_ctrl

Interface
REQ-001 Parameter START_X, 11'd300: frog respawn X.
REQ-002 Parameter START_Y, 11'd440: frog respawn Y.
REQ-003 Parameter HOP_STEP, 11'd40: X/Y distance per hop.
REQ-004 Parameter RIDE_STEP, 11'd20: X distance per pad move; equals the lilypad X step.
REQ-005 Parameter RIVER_Y_MIN/RIVER_Y_MAX, 11'd40/11'd200: inclusive river row band (Frog_Y).
REQ-006 Parameter DEATH_FRAMES, 6'd30; LIVES_INIT, 2'd3.
REQ-007 Ports SHALL be:
- frame_clk  in  1  frame-rate clock.
- Reset  in  1  asynchronous, active-high.
- keycode  in  8  USB keycode: 0x1A up, 0x16 down, 0x04 left, 0x07 right, 0x00 none.
- LPad_Collision  in  4  per-pad frog-overlap flags, bit i = pad i.
- LPad_Moved  in  4  per-pad strobe, high the frame pad i advanced.
- LPad_Dir  in  4  per-pad direction, 0 left, 1 right.
- Frog_X, Frog_Y  out  11  frog top-left position.
- Lives  out  2  remaining lives.
- Dead  out  1  death animation active.
- win, lose  out  1  game result, fed to every lilypad.

Function
REQ-008 States SHALL be ALIVE, SETTLE, DEAD, WIN, GAMEOVER.
REQ-009 Hop SHALL trigger only on keycode edge: current keycode is a direction code and the previous-frame keycode was 0x00.
REQ-010 In ALIVE, a hop SHALL update the position one frame after the edge and enter SETTLE for exactly 1 frame.
REQ-011 Hop clamps: left ignored if Frog_X < HOP_STEP; right ignored if Frog_X + 2*HOP_STEP > 640; down ignored if Frog_Y == START_Y; an ignored hop SHALL NOT enter SETTLE.
REQ-012 Up hop reaching Frog_Y == 0 SHALL enter WIN; win = 1 until Reset.
REQ-013 SETTLE SHALL ignore collision and ride inputs, then return to ALIVE; this covers the one-frame collision latency.
REQ-014 In ALIVE, with RIVER_Y_MIN <= Frog_Y <= RIVER_Y_MAX and LPad_Collision == 0, the block SHALL enter DEAD next frame.
REQ-015 Riding: in ALIVE in the river band, the lowest index i with LPad_Collision[i] & LPad_Moved[i] SHALL shift Frog_X by ±RIDE_STEP per LPad_Dir[i]; other pads are ignored that frame.
REQ-016 A ride making Frog_X < 0 (11-bit underflow, i.e. Frog_X < RIDE_STEP when moving left) or Frog_X + 40 > 640 SHALL enter DEAD instead of moving.
REQ-017 Hop edge and ride in the same frame: the hop wins; the ride is discarded.
REQ-018 Outside the river band, LPad inputs SHALL be ignored.
REQ-019 On DEAD entry, Lives SHALL decrement by 1 and Dead = 1; after DEAD_FRAMES frames, the block SHALL go to GAMEOVER if Lives == 0, else to ALIVE at (START_X, START_Y) with Dead = 0.
REQ-020 Keys SHALL be ignored in DEAD, WIN and GAMEOVER.
REQ-021 GAMEOVER SHALL drive lose = 1 and hold position until Reset.
REQ-022 win and lose SHALL never be high together.

Reset
REQ-023 Reset SHALL force ALIVE, Frog_X = START_X, Frog_Y = START_Y, Lives = LIVES_INIT, Dead = 0, win = 0, lose = 0, death counter 0, previous keycode 0x00.
REQ-024 Reset asserted mid-DEAD or mid-SETTLE SHALL abort immediately with no residual hop or ride.

Structure
REQ-025 Package frogger_pkg SHALL hold the keycode constants, screen/geometry constants (640, 480, 40) and the state enum typedef.
REQ-026 Sub-module frog_key_edge SHALL register keycode and output one-cycle hop strobes: up, down, left, right.

Verification
REQ-027 Reset, keycode 0x1A for 3 frames then 0x00 -> Frog_Y 440→400 once only; SETTLE 1 frame.
REQ-028 Frog at (0,440), keycode 0x04 -> position unchanged, state stays ALIVE.
REQ-029 Frog at (300,200), LPad_Collision=4'b0010, LPad_Moved=4'b0011, LPad_Dir=4'b0010 -> Frog_X 320; repeated 15 more moves -> X 620 attempt → DEAD, Lives 3→2.
REQ-030 Frog at (300,160), LPad_Collision=0 after SETTLE -> DEAD; after 30 frames respawn (300,440), Dead=0.
REQ-031 Three consecutive deaths -> Lives 0, GAMEOVER, lose=1, win=0; keys ignored.
REQ-032 Up hop from Y=40 -> Y=0, win=1; Reset asserted during DEAD → all outputs return to reset values next edge.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared keycodes, screen geometry and the frog controller state type.
package frogger_pkg;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;

  localparam logic [10:0] SCREEN_W  = 11'd640;
  localparam logic [10:0] SCREEN_H  = 11'd480;
  localparam logic [10:0] FROG_SIZE = 11'd40;

  typedef enum logic [2:0] {
    ALIVE,
    SETTLE,
    DEAD,
    WIN,
    GAMEOVER
  } frog_state_t;

  // {valid, index} of the lowest set bit; lower pad indices win ties.
  function automatic logic [2:0] lowest_pad(input logic [3:0] hits);
    logic [2:0] sel;
    sel = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (hits[i]) sel = {1'b1, 2'(i)};
    end
    return sel;
  endfunction

endpackage

// File: rtl/frog_key_edge.sv
// Turns a held USB keycode into single-frame hop strobes, firing only when
// a direction key appears after a frame with no key pressed.
module frog_key_edge
  import frogger_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right
);

  logic [7:0] prev_key_reg;
  logic       was_idle;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) prev_key_reg <= KEY_NONE;
    else       prev_key_reg <= keycode;
  end

  assign was_idle = (prev_key_reg == KEY_NONE);
  assign up       = was_idle && (keycode == KEY_UP);
  assign down     = was_idle && (keycode == KEY_DOWN);
  assign left     = was_idle && (keycode == KEY_LEFT);
  assign right    = was_idle && (keycode == KEY_RIGHT);

endmodule

// File: rtl/frog_rider_ctrl.sv
// Frog movement, lilypad riding, drowning, lives and win/lose control,
// advanced once per video frame.
module frog_rider_ctrl
  import frogger_pkg::*;
#(
  parameter logic [10:0] START_X     = 11'd300,
  parameter logic [10:0] START_Y     = 11'd440,
  parameter logic [10:0] HOP_STEP    = 11'd40,
  parameter logic [10:0] RIDE_STEP   = 11'd20,
  parameter logic [10:0] RIVER_Y_MIN = 11'd40,
  parameter logic [10:0] RIVER_Y_MAX = 11'd200,
  parameter logic [5:0]  DEAD_FRAMES = 6'd30,
  parameter logic [1:0]  LIVES_INIT  = 2'd3
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic [3:0]  LPad_Collision,
  input  logic [3:0]  LPad_Moved,
  input  logic [3:0]  LPad_Dir,
  output logic [10:0] Frog_X,
  output logic [10:0] Frog_Y,
  output logic [1:0]  Lives,
  output logic        Dead,
  output logic        win,
  output logic        lose
);

  frog_state_t state_reg;
  logic [5:0]  death_cnt_reg;

  logic        hop_up, hop_down, hop_left, hop_right;
  logic        hop_valid;
  logic [10:0] hop_x, hop_y;
  logic [11:0] x_wide;
  logic        in_river;
  logic [2:0]  pad_pick;
  logic        ride_valid, ride_right, ride_off_edge;
  logic [10:0] ride_x;

  frog_key_edge u_key_edge (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .up        (hop_up),
    .down      (hop_down),
    .left      (hop_left),
    .right     (hop_right)
  );

  assign x_wide = {1'b0, Frog_X};

  // A hop that would leave the playfield is dropped entirely.
  always_comb begin
    hop_valid = 1'b0;
    hop_x     = Frog_X;
    hop_y     = Frog_Y;
    if (hop_up && (Frog_Y >= HOP_STEP)) begin
      hop_valid = 1'b1;
      hop_y     = Frog_Y - HOP_STEP;
    end else if (hop_down && (Frog_Y != START_Y)) begin
      hop_valid = 1'b1;
      hop_y     = Frog_Y + HOP_STEP;
    end else if (hop_left && (Frog_X >= HOP_STEP)) begin
      hop_valid = 1'b1;
      hop_x     = Frog_X - HOP_STEP;
    end else if (hop_right && ((x_wide + {HOP_STEP, 1'b0}) <= {1'b0, SCREEN_W})) begin
      hop_valid = 1'b1;
      hop_x     = Frog_X + HOP_STEP;
    end
  end

  assign in_river      = (Frog_Y >= RIVER_Y_MIN) && (Frog_Y <= RIVER_Y_MAX);
  assign pad_pick      = lowest_pad(LPad_Collision & LPad_Moved);
  assign ride_valid    = pad_pick[2];
  assign ride_right    = LPad_Dir[pad_pick[1:0]];
  assign ride_off_edge = ride_right
                       ? ((x_wide + {1'b0, RIDE_STEP} + {1'b0, FROG_SIZE}) > {1'b0, SCREEN_W})
                       : (Frog_X < RIDE_STEP);
  assign ride_x        = ride_right ? (Frog_X + RIDE_STEP) : (Frog_X - RIDE_STEP);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= ALIVE;
      Frog_X        <= START_X;
      Frog_Y        <= START_Y;
      Lives         <= LIVES_INIT;
      Dead          <= 1'b0;
      win           <= 1'b0;
      lose          <= 1'b0;
      death_cnt_reg <= 6'd0;
    end else begin
      case (state_reg)
        ALIVE: begin
          if (hop_valid) begin
            Frog_X <= hop_x;
            Frog_Y <= hop_y;
            if (hop_y == 11'd0) begin
              state_reg <= WIN;
              win       <= 1'b1;
            end else begin
              state_reg <= SETTLE;
            end
          end else if (in_river && ((LPad_Collision == 4'd0) || (ride_valid && ride_off_edge))) begin
            state_reg     <= DEAD;
            Dead          <= 1'b1;
            Lives         <= Lives - 2'd1;
            death_cnt_reg <= 6'd0;
          end else if (in_river && ride_valid) begin
            Frog_X <= ride_x;
          end
        end
        // Collision flags still describe the old position for one frame.
        SETTLE: state_reg <= ALIVE;
        DEAD: begin
          if (death_cnt_reg == (DEAD_FRAMES - 6'd1)) begin
            death_cnt_reg <= 6'd0;
            Dead          <= 1'b0;
            if (Lives == 2'd0) begin
              state_reg <= GAMEOVER;
              lose      <= 1'b1;
            end else begin
              state_reg <= ALIVE;
              Frog_X    <= START_X;
              Frog_Y    <= START_Y;
            end
          end else begin
            death_cnt_reg <= death_cnt_reg + 6'd1;
          end
        end
        WIN, GAMEOVER: ;
        default: state_reg <= ALIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_frog_rider_ctrl.sv
// Directed game scenarios followed by random play, each frame compared
// against a position/lives/timer model of the game rules.
module tb_frog_rider_ctrl;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  keycode = 8'h00;
  logic [3:0]  LPad_Collision = 4'h0;
  logic [3:0]  LPad_Moved = 4'h0;
  logic [3:0]  LPad_Dir = 4'h0;
  logic [10:0] Frog_X, Frog_Y;
  logic [1:0]  Lives;
  logic        Dead, win, lose;

  frog_rider_ctrl dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .keycode        (keycode),
    .LPad_Collision (LPad_Collision),
    .LPad_Moved     (LPad_Moved),
    .LPad_Dir       (LPad_Dir),
    .Frog_X         (Frog_X),
    .Frog_Y         (Frog_Y),
    .Lives          (Lives),
    .Dead           (Dead),
    .win            (win),
    .lose           (lose)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference game state: plain integers, death tracked as frames remaining.
  int mx, my, mlives, dead_left, mprev;
  bit mwin, mlose, settle;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_dir(input int k);
    return (k == 8'h1A) || (k == 8'h16) || (k == 8'h04) || (k == 8'h07);
  endfunction

  task automatic model_reset();
    mx = 300; my = 440; mlives = 3; dead_left = 0; mprev = 0;
    mwin = 0; mlose = 0; settle = 0;
  endtask

  task automatic model_kill();
    mlives = mlives - 1;
    dead_left = 30;
  endtask

  task automatic model_step(input int k, input int c, input int m, input int d);
    bit edge_seen;
    int nx, ny;
    edge_seen = (mprev == 0) && is_dir(k);
    mprev = k;
    if (mwin || mlose) return;
    if (dead_left > 0) begin
      dead_left = dead_left - 1;
      if (dead_left == 0) begin
        if (mlives == 0) mlose = 1;
        else begin mx = 300; my = 440; end
      end
      return;
    end
    if (settle) begin settle = 0; return; end
    if (edge_seen) begin
      nx = mx; ny = my;
      if (k == 8'h1A) ny = my - 40;
      if (k == 8'h16) ny = my + 40;
      if (k == 8'h04) nx = mx - 40;
      if (k == 8'h07) nx = mx + 40;
      if (ny >= 0 && !(k == 8'h16 && my == 440) && nx >= 0 && nx + 40 <= 640) begin
        mx = nx; my = ny;
        if (my == 0) mwin = 1; else settle = 1;
        return;
      end
    end
    if (my >= 40 && my <= 200) begin
      if (c == 0) begin model_kill(); return; end
      for (int i = 0; i < 4; i++) begin
        if (c[i] && m[i]) begin
          nx = mx + (d[i] ? 20 : -20);
          if (nx < 0 || nx + 40 > 640) model_kill();
          else mx = nx;
          break;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("X", int'(Frog_X), mx);
    check("Y", int'(Frog_Y), my);
    check("Lives", int'(Lives), mlives);
    check("Dead", int'(Dead), (dead_left > 0) ? 1 : 0);
    check("win", int'(win), int'(mwin));
    check("lose", int'(lose), int'(mlose));
    check("win_lose_excl", int'(win && lose), 0);
  endtask

  task automatic step(input int k, input int c, input int m, input int d);
    keycode = 8'(k); LPad_Collision = 4'(c); LPad_Moved = 4'(m); LPad_Dir = 4'(d);
    model_step(k, c, m, d);
    @(negedge frame_clk);
    compare_all();
  endtask

  task automatic hop(input int k, input int c);
    step(k, c, 0, 0);
    step(0, c, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    keycode = 8'h00; LPad_Collision = 4'h0; LPad_Moved = 4'h0; LPad_Dir = 4'h0;
    Reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got 0 expected 1 (run did not finish)");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, c;
    #2;
    do_reset();
    $display("reset: X=%0d Y=%0d Lives=%0d", Frog_X, Frog_Y, Lives);

    for (int i = 0; i < 3; i++) step(8'h1A, 0, 0, 0);
    check("hop_once_y", int'(Frog_Y), 400);
    step(0, 0, 0, 0);
    $display("held up key: Y=%0d", Frog_Y);

    hop(8'h16, 0);
    step(8'h16, 0, 0, 0);
    check("clamp_down_y", int'(Frog_Y), 440);
    step(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) hop(8'h04, 0);
    step(8'h04, 0, 0, 0);
    check("clamp_left_x", int'(Frog_X), 20);
    step(0, 0, 0, 0);
    for (int i = 0; i < 14; i++) hop(8'h07, 0);
    step(8'h07, 0, 0, 0);
    check("clamp_right_x", int'(Frog_X), 580);
    step(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) hop(8'h04, 0);
    $display("clamps: X=%0d Y=%0d", Frog_X, Frog_Y);

    for (int i = 0; i < 6; i++) hop(8'h1A, 4'b0010);
    check("river_y", int'(Frog_Y), 200);
    step(0, 4'b0010, 4'b0011, 4'b0010);
    check("ride_first_x", int'(Frog_X), 320);
    for (int i = 0; i < 15; i++) step(0, 4'b0010, 4'b0011, 4'b0010);
    check("ride_edge_dead", int'(Dead), 1);
    check("ride_edge_x", int'(Frog_X), 600);
    check("ride_edge_lives", int'(Lives), 2);
    idle(30);
    check("respawn_x", int'(Frog_X), 300);
    check("respawn_y", int'(Frog_Y), 440);
    check("respawn_dead", int'(Dead), 0);
    $display("ride off edge: Lives=%0d", Lives);

    for (int i = 0; i < 7; i++) hop(8'h1A, 4'b0010);
    step(8'h07, 4'b0010, 4'b0010, 4'b0010);
    check("hop_beats_ride_x", int'(Frog_X), 340);
    step(0, 0, 0, 0);
    check("settle_no_drown", int'(Dead), 0);
    step(0, 0, 0, 0);
    check("drown_dead", int'(Dead), 1);
    idle(30);
    $display("drown: Lives=%0d", Lives);

    for (int i = 0; i < 6; i++) hop(8'h1A, 4'b0001);
    step(0, 0, 0, 0);
    idle(30);
    check("gameover_lose", int'(lose), 1);
    check("gameover_win", int'(win), 0);
    check("gameover_lives", int'(Lives), 0);
    hop(8'h1A, 0);
    check("gameover_hold_y", int'(Frog_Y), 200);
    $display("game over: lose=%0d", lose);

    do_reset();
    for (int i = 0; i < 11; i++) hop(8'h1A, 4'b0001);
    check("win_flag", int'(win), 1);
    check("win_y", int'(Frog_Y), 0);
    $display("win: win=%0d", win);

    do_reset();
    step(8'h1A, 0, 0, 0);
    do_reset();
    check("reset_settle_y", int'(Frog_Y), 440);
    idle(2);
    for (int i = 0; i < 6; i++) hop(8'h1A, 4'b0001);
    step(0, 0, 0, 0);
    idle(5);
    do_reset();
    check("reset_dead_lives", int'(Lives), 3);
    check("reset_dead_flag", int'(Dead), 0);
    idle(2);
    $display("reset mid-settle/mid-dead: Y=%0d Lives=%0d", Frog_Y, Lives);

    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      for (int f = 0; f < 300; f++) begin
        case ($urandom_range(0, 11))
          0, 1, 2: k = 8'h1A;
          3:       k = 8'h04;
          4:       k = 8'h07;
          5:       k = 8'h16;
          6:       k = 8'h55;
          default: k = 8'h00;
        endcase
        c = ($urandom_range(0, 24) == 0) ? 0 : int'($urandom_range(1, 15));
        step(k, c, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end
      $display("episode %0d: X=%0d Y=%0d Lives=%0d win=%0d lose=%0d",
               ep, Frog_X, Frog_Y, Lives, win, lose);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
